dmem_stall_resp: RTL
====================

# dmem_stall_resp

Multi-cycle data-memory responder for the pipelined processor's memory stage. It accepts one read or write request at a time, asserts Stall back to the pipeline while the access is outstanding, and pulses Done when read data is valid or the write has committed. A small direct-mapped tag store models hit/miss latency and drives CacheHit, which feeds the bench's DCacheReq/DCacheHit counters.

## Interface
- ADDR_W, 12: word-address width; memory holds 2^ADDR_W 16-bit words.
- LINE_BITS, 3: tag-store index width; 2^LINE_BITS single-word lines.
- LATENCY, 4: miss latency in cycles from request acceptance to Done; must be ≥2 (elaboration error otherwise).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- Addr  in  16  byte address; word index = Addr[ADDR_W:1].
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataOut  out  16  read data; valid only while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  pipeline must hold the memory stage.
- CacheHit  out  1  qualifies Done; 1 = access hit the tag store.
- err  out  1  qualifies Done; 1 = request was illegal, no access performed.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if Rd|Wr, the request is accepted. Addr, DataIn, Rd and Wr are latched, and the hit is evaluated as valid[idx] && tag[idx]==Addr[15:LINE_BITS+1], with idx = Addr[LINE_BITS:1].
  - Hit or err: next state is RESP.
  - Miss: next state is WAIT, with the counter loaded to LATENCY-2.
- WAIT: counter decrements each cycle; at 0, next state is RESP.
- RESP: Done=1 for exactly one cycle, then IDLE. Rd/Wr are ignored in RESP.
- Illegal requests: Addr[0]=1 or Rd&&Wr. err=1 at Done, CacheHit=0, memory and tag store untouched.
- Commit happens on the edge entering RESP:
  - Write: mem[word]←DataIn.
  - Read: DataOut←mem[word].
  - Both: valid[idx]←1 and tag[idx]←tag (write-through, write-allocate).
- DataOut, CacheHit and err are registered and held at 0 outside RESP.
- Memory array is zero at time 0. rst does not alter memory contents.

## Timing
- Cycle 0 = IDLE with Rd|Wr sampled.
- Stall = (IDLE && (Rd||Wr)) || WAIT. This is combinational, so it is high in cycle 0 and low in the Done cycle.
- Hit or err: Done in cycle 1. Stall is high in cycle 0 only.
- Miss: Done in cycle LATENCY. Stall is high in cycles 0..LATENCY-1.
- Requester deasserts Rd/Wr in the cycle after Done unless it is issuing a new request. That cycle is IDLE, so back-to-back spacing is 1 cycle plus latency.
- Request inputs may change after cycle 0; the latched copies are used.
- Reset values: state=IDLE, Done=0, Stall=0 when Rd=Wr=0, DataOut=0, CacheHit=0, err=0, all valid bits cleared.
- rst during WAIT or RESP: the access is aborted with no Done. A write is not committed if the RESP edge has not yet occurred.
- rst has priority over a simultaneous request; the request is not accepted that cycle.

## Configuration
- DMEM_HIT_TRACK_EN defined: tag store, hit path and CacheHit are as above.
- DMEM_HIT_TRACK_EN undefined:
  - No tag store; every legal access takes LATENCY cycles.
  - CacheHit is tied 0.
  - err accesses still complete in 1 cycle.

## Test plan
Parameters: LATENCY=4, LINE_BITS=3, macro defined unless stated.
- Reset: assert rst for 2 cycles with Rd=1 → Done=0, DataOut=0, CacheHit=0, err=0 throughout; no request is accepted.
- Cold write: Wr Addr=0x0010 DataIn=0x1234 → Stall high in cycles 0–3, Done in cycle 4, CacheHit=0, err=0.
- Hit read: then Rd 0x0010 → Done in cycle 1, CacheHit=1, DataOut=0x1234. Without the macro: Done in cycle 4, CacheHit=0.
- Conflict: Rd 0x0110 (same idx 0, different tag) → miss, Done in cycle 4, DataOut=0x0000. A following Rd 0x0010 misses and returns DataOut=0x1234.
- Errors: Rd 0x0011 → Done in cycle 1, err=1. Rd=Wr=1 at 0x0020 with DataIn=0xBEEF → err=1, and a later Rd 0x0020 returns 0x0000.
- Abort: Wr 0x0040 DataIn=0x5555 miss, rst in cycle 2 → no Done. A later Rd 0x0040 returns 0x0000 as a miss.

Source files
------------

// File: rtl/dmem_stall_resp.sv
// dmem_stall_resp: a multi-cycle data-memory responder for the memory stage.
// It accepts one request at a time. Stall stays high while the access is
// outstanding, and Done pulses for one cycle when the access completes.
// Define the macro DMEM_HIT_TRACK_EN to enable the direct-mapped tag store
// and the CacheHit path. Without it, every legal access takes LATENCY cycles.
module dmem_stall_resp #(
    parameter int ADDR_W    = 12,
    parameter int LINE_BITS = 3,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);
    // LATENCY >= 2 is enforced below, so the counter is at least 1 bit wide.
    localparam int CNT_W = $clog2(LATENCY);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    generate
        if (LATENCY < 2 || LINE_BITS > ADDR_W || ADDR_W > 15) begin : g_bad_params
            $error("dmem_stall_resp: need LATENCY >= 2 and LINE_BITS <= ADDR_W <= 15");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;

    // Copy of a missing request, held while the FSM waits in WAIT.
    logic [ADDR_W-1:0]  r_word;
    logic               r_wr;
    logic [15:0]        r_wdata;

    logic [15:0]        r_mem [DEPTH];
    logic [15:0]        r_data_out;
    logic               r_cache_hit;
    logic               r_err;

    logic               w_req;
    logic               w_req_err;
    logic               w_accept;
    logic               w_hit;
    logic               w_enter_resp;
    logic               w_commit;
    logic [ADDR_W-1:0]  w_cmt_word;
    logic               w_cmt_wr;
    logic [15:0]        w_cmt_data;

    assign w_req     = Rd | Wr;
    assign w_req_err = Addr[0] | (Rd & Wr);
    assign w_accept  = (r_state == IDLE) && w_req;

    // A hit or an error request enters RESP straight from IDLE, so the commit
    // on that edge uses the live inputs. A miss commits from the latched copy.
    assign w_cmt_word = (r_state == IDLE) ? Addr[ADDR_W:1] : r_word;
    assign w_cmt_wr   = (r_state == IDLE) ? Wr             : r_wr;
    assign w_cmt_data = (r_state == IDLE) ? DataIn         : r_wdata;

    // Reset has priority: an access that reset aborts never reaches RESP.
    assign w_enter_resp = (w_next_state == RESP) && !rst;
    assign w_commit     = w_enter_resp && ((r_state != IDLE) || !w_req_err);

    assign Done     = (r_state == RESP);
    assign DataOut  = r_data_out;
    assign CacheHit = r_cache_hit;
    assign err      = r_err;

    // Next-state and Stall decode
    // NOTE: every output of a combinational block gets a default value first, so that no path leaves it unassigned and a latch is inferred.
    always_comb begin
        w_next_state = r_state;
        Stall        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    Stall = 1'b1;
                    if (w_req_err || w_hit) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and miss-latency counter
    // NOTE: sequential state uses non-blocking assignments, so that every flop samples values from before the edge, regardless of the order of the blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= CNT_W'(LATENCY - 2);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Latch the accepted request so the requester may change its inputs afterwards
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word  <= Addr[ADDR_W:1];
            r_wr    <= Wr;
            r_wdata <= DataIn;
        end
    end

    // Write commit into the data array on the edge that enters RESP
    // NOTE: the memory array has no reset term. rst leaves its contents alone, and a reset loop over every word would not map onto a RAM.
    always_ff @(posedge clk) begin
        if (w_commit && w_cmt_wr) begin
            r_mem[w_cmt_word] <= w_cmt_data;
        end
    end

    // Response registers: load when entering RESP, zero in every other cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_cache_hit <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_enter_resp) begin
            r_data_out  <= (w_commit && !w_cmt_wr) ? r_mem[w_cmt_word] : '0;
            r_cache_hit <= (r_state == IDLE) && w_hit && !w_req_err;
            r_err       <= (r_state == IDLE) && w_req_err;
        end else begin
            r_data_out  <= '0;
            r_cache_hit <= 1'b0;
            r_err       <= 1'b0;
        end
    end

`ifdef DMEM_HIT_TRACK_EN
    localparam int TAG_W = 16 - LINE_BITS - 1;
    localparam int LINES = 1 << LINE_BITS;

    logic [LINES-1:0]     r_valid;
    logic [TAG_W-1:0]     r_tag [LINES];
    logic [TAG_W-1:0]     r_req_tag;
    logic [LINE_BITS-1:0] w_idx;
    logic [LINE_BITS-1:0] w_cmt_idx;
    logic [TAG_W-1:0]     w_cmt_tag;

    assign w_idx     = Addr[LINE_BITS:1];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == Addr[15:LINE_BITS+1]);
    assign w_cmt_idx = w_cmt_word[LINE_BITS-1:0];
    assign w_cmt_tag = (r_state == IDLE) ? Addr[15:LINE_BITS+1] : r_req_tag;

    // Valid bits: cleared by reset, set by every committed legal access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_commit) begin
            r_valid[w_cmt_idx] <= 1'b1;
        end
    end

    // Tag array and the latched request tag. Only a valid bit makes a tag meaningful.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req_tag <= Addr[15:LINE_BITS+1];
        end
        if (w_commit) begin
            r_tag[w_cmt_idx] <= w_cmt_tag;
        end
    end
`else
    assign w_hit = 1'b0;

    // The upper address bits only feed the tag compare, which is absent in this build.
    generate
        if (ADDR_W < 15) begin : g_unused_addr
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^Addr[15:ADDR_W+1];
        end
    endgenerate
`endif

endmodule
